ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_pkg.sv | 40 ++++
 rtl/ctrl_seq_decode.sv | 84 ++++++++
 rtl/ctrl_seq.sv | 147 ++++++++++++++
 tb/tb_ctrl_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg -- shared encodings for the call/return control sequencer.
//   Instruction fields: type in inst[2:0], function in inst[6:3],
//   branch condition-code index in inst[8+] (used only with CTRL_BCOND_EN).
//   Also holds the sequencer mode encoding and the datapath strobe bundle.
package ctrl_seq_pkg;

  // Instruction types (inst[2:0]); 0, 6 and 7 are unassigned.
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_B = 3'd2;
  localparam logic [2:0] TYPE_J = 3'd3;
  localparam logic [2:0] TYPE_M = 3'd4;
  localparam logic [2:0] TYPE_S = 3'd5;

  // Function codes (inst[6:3]), interpreted per type.
  localparam logic [3:0] FN_LINK  = 4'd0;  // J_TYPE: write link only
  localparam logic [3:0] FN_JUMP  = 4'd1;  // J_TYPE: write link and redirect PC
  localparam logic [3:0] FN_LOAD  = 4'd0;  // M_TYPE
  localparam logic [3:0] FN_STORE = 4'd1;  // M_TYPE
  localparam logic [3:0] FN_CALL  = 4'd0;  // S_TYPE
  localparam logic [3:0] FN_RET   = 4'd1;  // S_TYPE

  // Sequencer modes; encoding 3 is reserved and never produced.
  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SAVE    = 2'd1,
    MODE_RESTORE = 2'd2
  } mode_t;

  // Datapath strobes, same meaning as the single-cycle decoder.
  typedef struct packed {
    logic pc_sel;   // 0: PC+4, 1: ALU target
    logic b_sel;    // 0: RS2, 1: IMM
    logic dmem_we;  // data-memory store
    logic wb_sel;   // 0: ALU, 1: DMEM
    logic reg_we;   // register-file write
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '0;

endpackage

// File: rtl/ctrl_seq_decode.sv
// ctrl_decode -- single-cycle combinational instruction decode.
//   inst        : current instruction
//   inst_valid  : inst is valid this cycle; when low every output is 0
//   ccr         : condition codes for B_TYPE
//   strb        : datapath strobes for the RUN state
//   is_call     : valid S_TYPE CALL
//   is_ret      : valid S_TYPE RET
// Build option CTRL_BCOND_EN: B_TYPE picks ccr[inst[8+k:8]] (k = clog2(CCR_W)-1),
// an out-of-range index is "not taken". Without it B_TYPE uses ccr[0] only.
module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CCR_W = 4
) (
  input  logic [XLEN-1:0]  inst,
  input  logic             inst_valid,
  input  logic [CCR_W-1:0] ccr,
  output strobes_t         strb,
  output logic             is_call,
  output logic             is_ret
);

  localparam int BIDX_W = (CCR_W > 1) ? $clog2(CCR_W) : 1;

  logic [2:0] op_type;
  logic [3:0] func;
  logic       br_taken;
  logic       unused_bits;

  assign op_type = inst[2:0];
  assign func    = inst[6:3];

`ifdef CTRL_BCOND_EN
  logic [BIDX_W-1:0] bidx;

  assign bidx        = inst[8 +: BIDX_W];
  assign br_taken    = (32'(bidx) < CCR_W) ? ccr[bidx] : 1'b0;
  assign unused_bits = ^{inst[XLEN-1:8+BIDX_W], inst[7]};
`else
  assign br_taken    = ccr[0];
  assign unused_bits = ^{inst[XLEN-1:7], ccr[CCR_W-1:1]};
`endif

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    strb    = STROBES_IDLE;
    is_call = 1'b0;
    is_ret  = 1'b0;
    if (inst_valid) begin
      case (op_type)
        TYPE_I: begin
          strb.b_sel  = 1'b1;
          strb.reg_we = 1'b1;
        end
        TYPE_B: strb.pc_sel = br_taken;
        TYPE_J: begin
          if (func == FN_LINK) begin
            strb.reg_we = 1'b1;
          end else if (func == FN_JUMP) begin
            strb.reg_we = 1'b1;
            strb.pc_sel = 1'b1;
          end
        end
        TYPE_M: begin
          if (func == FN_LOAD) begin
            strb.b_sel  = 1'b1;
            strb.wb_sel = 1'b1;
            strb.reg_we = 1'b1;
          end else if (func == FN_STORE) begin
            strb.b_sel   = 1'b1;
            strb.dmem_we = 1'b1;
          end
        end
        TYPE_S: begin
          is_call = (func == FN_CALL);
          is_ret  = (func == FN_RET);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq -- control sequencer: single-cycle decode plus a CALL/RET
// spill/fill engine that stalls fetch for NSAVE cycles per CALL or RET.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   inst, inst_valid  : instruction and its valid (ignored while stalled)
//   ccr               : condition codes
//   pc_sel, b_sel, dmem_we, wb_sel, reg_we : datapath strobes
//   stall             : hold PC and fetch (SAVE or RESTORE in progress)
//   sc                : spill/fill step counter
//   mode              : 0 RUN, 1 SAVE, 2 RESTORE
//   depth             : current CALL nesting level (saturates, never wraps)
//   ovf_err, unf_err  : sticky CALL-overflow / RET-underflow, cleared by reset
// Build option CTRL_BCOND_EN selects the indexed branch condition (see ctrl_decode).
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NSAVE = 16,
  parameter int DEPTH = 8,
  parameter int CCR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [XLEN-1:0]         inst,
  input  logic                    inst_valid,
  input  logic [CCR_W-1:0]        ccr,
  output logic                    pc_sel,
  output logic                    b_sel,
  output logic                    dmem_we,
  output logic                    wb_sel,
  output logic                    reg_we,
  output logic                    stall,
  output logic [$clog2(NSAVE):0]  sc,
  output logic [1:0]              mode,
  output logic [7:0]              depth,
  output logic                    ovf_err,
  output logic                    unf_err
);

  localparam int             SC_W      = $clog2(NSAVE) + 1;
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(NSAVE - 1);
  localparam logic [7:0]     DEPTH_MAX = 8'(DEPTH);

  mode_t           mode_q;
  logic [SC_W-1:0] sc_q;
  logic [7:0]      depth_q;
  logic            ovf_q;
  logic            unf_q;
  logic            run_en;   // low until the first edge after reset release
  strobes_t        dec_strb;
  strobes_t        strb;
  logic            is_call;
  logic            is_ret;

  ctrl_decode #(
    .XLEN  (XLEN),
    .CCR_W (CCR_W)
  ) u_decode (
    .inst       (inst),
    .inst_valid (inst_valid),
    .ccr        (ccr),
    .strb       (dec_strb),
    .is_call    (is_call),
    .is_ret     (is_ret)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_RUN;
      sc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      run_en  <= 1'b0;
    end else begin
      run_en <= 1'b1;
      case (mode_q)
        MODE_RUN: begin
          if (run_en && is_call) begin
            if (depth_q < DEPTH_MAX) begin
              mode_q <= MODE_SAVE;
              sc_q   <= '0;
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (run_en && is_ret) begin
            if (depth_q != 8'd0) begin
              mode_q <= MODE_RESTORE;
              sc_q   <= '0;
            end else begin
              unf_q <= 1'b1;
            end
          end
        end
        MODE_SAVE: begin
          if (sc_q == SC_LAST) begin
            mode_q  <= MODE_RUN;
            sc_q    <= '0;
            depth_q <= depth_q + 8'd1;
          end else begin
            sc_q <= sc_q + SC_W'(1);
          end
        end
        MODE_RESTORE: begin
          if (sc_q == SC_LAST) begin
            mode_q  <= MODE_RUN;
            sc_q    <= '0;
            depth_q <= depth_q - 8'd1;
          end else begin
            sc_q <= sc_q + SC_W'(1);
          end
        end
        default: mode_q <= MODE_RUN;
      endcase
    end
  end

  // Strobes follow the decoder in RUN; SAVE/RESTORE drive the fixed spill/fill
  // pattern. Everything is held off until run_en is set.
  always_comb begin
    strb = STROBES_IDLE;
    if (run_en) begin
      case (mode_q)
        MODE_RUN: strb = dec_strb;
        MODE_SAVE: begin
          strb.dmem_we = 1'b1;
          strb.b_sel   = 1'b1;
        end
        MODE_RESTORE: begin
          strb.wb_sel = 1'b1;
          strb.reg_we = 1'b1;
          strb.b_sel  = 1'b1;
        end
        default: strb = STROBES_IDLE;
      endcase
    end
  end

  assign {pc_sel, b_sel, dmem_we, wb_sel, reg_we} = strb;
  assign stall   = (mode_q != MODE_RUN);
  assign sc      = sc_q;
  assign mode    = mode_q;
  assign depth   = depth_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq -- directed self-checking bench for ctrl_seq (NSAVE=16, DEPTH=2).
// Output snapshot layout: {pc_sel,b_sel,dmem_we,wb_sel,reg_we, stall, mode[1:0],
// sc[4:0], depth[7:0], ovf_err, unf_err}.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic [3:0]  ccr;
  logic        pc_sel, b_sel, dmem_we, wb_sel, reg_we, stall;
  logic [4:0]  sc;
  logic [1:0]  mode;
  logic [7:0]  depth;
  logic        ovf_err, unf_err;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [22:0] obs;
  logic [22:0] exp_v;

  // Hand-derived strobe patterns {pc_sel,b_sel,dmem_we,wb_sel,reg_we}.
  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_I     = 5'b01001;
  localparam logic [4:0] S_LINK  = 5'b00001;
  localparam logic [4:0] S_JUMP  = 5'b10001;
  localparam logic [4:0] S_LOAD  = 5'b01011;
  localparam logic [4:0] S_STORE = 5'b01100;
  localparam logic [4:0] S_SAVE  = 5'b01100;
  localparam logic [4:0] S_REST  = 5'b01011;
  localparam logic [4:0] S_BR    = 5'b10000;

`ifdef CTRL_BCOND_EN
  localparam logic BC12 = 1'b1;  // ccr=0100, idx 2 -> ccr[2]
  localparam logic BC13 = 1'b0;  // ccr=0001, idx 2 -> ccr[2]
  localparam logic BC14 = 1'b1;  // ccr=1000, idx 3 -> ccr[3]
`else
  localparam logic BC12 = 1'b0;  // ccr[0] only
  localparam logic BC13 = 1'b1;
  localparam logic BC14 = 1'b0;
`endif

  ctrl_seq #(
    .XLEN  (32),
    .NSAVE (16),
    .DEPTH (2),
    .CCR_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .inst_valid (inst_valid),
    .ccr        (ccr),
    .pc_sel     (pc_sel),
    .b_sel      (b_sel),
    .dmem_we    (dmem_we),
    .wb_sel     (wb_sel),
    .reg_we     (reg_we),
    .stall      (stall),
    .sc         (sc),
    .mode       (mode),
    .depth      (depth),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Upper bits carry junk that the decoder must ignore.
  function automatic logic [31:0] mk(input logic [2:0] t, input logic [3:0] f,
                                     input logic [1:0] bi);
    return 32'h5A00_0000 | (32'(bi) << 8) | (32'(f) << 3) | 32'(t);
  endfunction

  function automatic logic [22:0] snap();
    return {pc_sel, b_sel, dmem_we, wb_sel, reg_we, stall, mode, sc, depth,
            ovf_err, unf_err};
  endfunction

  function automatic logic [22:0] ev(input logic [4:0] s, input logic st,
                                     input logic [1:0] m, input logic [4:0] c,
                                     input logic [7:0] d, input logic o,
                                     input logic u);
    return {s, st, m, c, d, o, u};
  endfunction

  task automatic test_reset();
    rst_n      = 1'b0;
    inst       = mk(TYPE_M, FN_LOAD, 2'd0);
    inst_valid = 1'b1;
    ccr        = 4'hF;
    #3;
    exp_v = ev(S_NONE, 0, 2'd0, 5'd0, 8'd0, 0, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL reset_hold: got %b want %b", obs, exp_v); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL run_en_gate: got %b want %b", obs, exp_v); else n_pass++;
    @(posedge clk); #1;
    exp_v = ev(S_LOAD, 0, 2'd0, 5'd0, 8'd0, 0, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL load_after_reset: got %b want %b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_decode();
    logic [41:0] vec [16];
    logic        v_valid;
    logic [31:0] v_inst;
    logic [3:0]  v_ccr;
    logic [4:0]  v_exp;
    vec[0]  = {1'b1, mk(TYPE_I, 4'd5, 2'd0),     4'h0,    S_I};
    vec[1]  = {1'b1, mk(TYPE_J, FN_LINK, 2'd0),  4'h0,    S_LINK};
    vec[2]  = {1'b1, mk(TYPE_J, FN_JUMP, 2'd0),  4'h0,    S_JUMP};
    vec[3]  = {1'b1, mk(TYPE_J, 4'd7, 2'd0),     4'h0,    S_NONE};
    vec[4]  = {1'b1, mk(TYPE_M, FN_STORE, 2'd0), 4'h0,    S_STORE};
    vec[5]  = {1'b1, mk(TYPE_M, 4'd3, 2'd0),     4'h0,    S_NONE};
    vec[6]  = {1'b1, mk(3'd7, 4'd0, 2'd0),       4'h0,    S_NONE};
    vec[7]  = {1'b1, mk(3'd0, 4'd0, 2'd0),       4'h0,    S_NONE};
    vec[8]  = {1'b0, mk(TYPE_M, FN_LOAD, 2'd0),  4'h0,    S_NONE};
    vec[9]  = {1'b0, mk(TYPE_S, FN_CALL, 2'd0),  4'h0,    S_NONE};
    vec[10] = {1'b1, mk(TYPE_B, 4'd0, 2'd0),     4'b0001, S_BR};
    vec[11] = {1'b1, mk(TYPE_B, 4'd0, 2'd0),     4'b1110, S_NONE};
    vec[12] = {1'b1, mk(TYPE_B, 4'd0, 2'd2),     4'b0100, {BC12, 4'b0000}};
    vec[13] = {1'b1, mk(TYPE_B, 4'd0, 2'd2),     4'b0001, {BC13, 4'b0000}};
    vec[14] = {1'b1, mk(TYPE_B, 4'd0, 2'd3),     4'b1000, {BC14, 4'b0000}};
    vec[15] = {1'b1, mk(TYPE_S, 4'd5, 2'd0),     4'h0,    S_NONE};
    for (int k = 0; k < 16; k++) begin
      {v_valid, v_inst, v_ccr, v_exp} = vec[k];
      @(negedge clk);
      inst       = v_inst;
      inst_valid = v_valid;
      ccr        = v_ccr;
      #1;
      exp_v = ev(v_exp, 0, 2'd0, 5'd0, 8'd0, 0, 0);
      obs = snap(); n_total++;
      if (obs !== exp_v) $display("FAIL decode_vec%0d: got %b want %b", k, obs, exp_v); else n_pass++;
    end
  endtask

  task automatic test_call_save();
    @(negedge clk);
    inst       = mk(TYPE_S, FN_CALL, 2'd0);
    inst_valid = 1'b1;
    #1;
    exp_v = ev(S_NONE, 0, 2'd0, 5'd0, 8'd0, 0, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL call_accept: got %b want %b", obs, exp_v); else n_pass++;
    @(posedge clk); #1;
    inst = mk(TYPE_M, FN_LOAD, 2'd0);  // must be ignored while stalled
    #1;
    for (int i = 0; i < 16; i++) begin
      exp_v = ev(S_SAVE, 1, 2'd1, 5'(i), 8'd0, 0, 0);
      obs = snap(); n_total++;
      if (obs !== exp_v) $display("FAIL save_step%0d: got %b want %b", i, obs, exp_v); else n_pass++;
      @(posedge clk); #1;
    end
    exp_v = ev(S_LOAD, 0, 2'd0, 5'd0, 8'd1, 0, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL save_done: got %b want %b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_overflow();
    int cnt;
    @(negedge clk);
    inst       = mk(TYPE_S, FN_CALL, 2'd0);
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    cnt = 0;
    while (mode != 2'd0 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_total++;
    if (cnt !== 16) $display("FAIL save2_latency: got %0d want 16", cnt); else n_pass++;
    exp_v = ev(S_NONE, 0, 2'd0, 5'd0, 8'd2, 0, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL depth_two: got %b want %b", obs, exp_v); else n_pass++;
    @(negedge clk);
    inst       = mk(TYPE_S, FN_CALL, 2'd0);
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    exp_v = ev(S_NONE, 0, 2'd0, 5'd0, 8'd2, 1, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL ovf_call: got %b want %b", obs, exp_v); else n_pass++;
    @(posedge clk); #1;
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL ovf_no_stall: got %b want %b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_restore();
    int cnt;
    @(negedge clk);
    inst       = mk(TYPE_S, FN_RET, 2'd0);
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst = mk(TYPE_M, FN_STORE, 2'd0);  // must be ignored while stalled
    #1;
    for (int i = 0; i < 16; i++) begin
      exp_v = ev(S_REST, 1, 2'd2, 5'(i), 8'd2, 1, 0);
      obs = snap(); n_total++;
      if (obs !== exp_v) $display("FAIL restore_step%0d: got %b want %b", i, obs, exp_v); else n_pass++;
      @(posedge clk); #1;
    end
    exp_v = ev(S_STORE, 0, 2'd0, 5'd0, 8'd1, 1, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL restore_done: got %b want %b", obs, exp_v); else n_pass++;
    @(negedge clk);
    inst = mk(TYPE_S, FN_RET, 2'd0);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    cnt = 0;
    while (mode != 2'd0 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_total++;
    if (cnt !== 16) $display("FAIL restore2_latency: got %0d want 16", cnt); else n_pass++;
    exp_v = ev(S_NONE, 0, 2'd0, 5'd0, 8'd0, 1, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL depth_zero: got %b want %b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_underflow();
    @(negedge clk);
    inst       = mk(TYPE_S, FN_RET, 2'd0);
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    exp_v = ev(S_NONE, 0, 2'd0, 5'd0, 8'd0, 1, 1);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL unf_ret: got %b want %b", obs, exp_v); else n_pass++;
    @(posedge clk); #1;
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL unf_no_stall: got %b want %b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_async_reset();
    int cnt;
    @(negedge clk);
    inst       = mk(TYPE_S, FN_CALL, 2'd0);
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    cnt = 0;
    while (mode != 2'd0 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    @(negedge clk);
    inst       = mk(TYPE_S, FN_RET, 2'd0);
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst       = mk(TYPE_M, FN_LOAD, 2'd0);
    cnt = 0;
    while (sc != 5'd7 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    exp_v = ev(S_REST, 1, 2'd2, 5'd7, 8'd1, 1, 1);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL restore_sc7: got %b want %b", obs, exp_v); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = ev(S_NONE, 0, 2'd0, 5'd0, 8'd0, 0, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL async_reset: got %b want %b", obs, exp_v); else n_pass++;
    @(posedge clk); #1;
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL reset_held_edge: got %b want %b", obs, exp_v); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL rerun_gate: got %b want %b", obs, exp_v); else n_pass++;
    @(posedge clk); #1;
    exp_v = ev(S_LOAD, 0, 2'd0, 5'd0, 8'd0, 0, 0);
    obs = snap(); n_total++;
    if (obs !== exp_v) $display("FAIL rerun_load: got %b want %b", obs, exp_v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_call_save();
    test_overflow();
    test_restore();
    test_underflow();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
